// File: rtl/dma_vram_rd_char.sv
// Read-side VRAM DMA: fetches a run of character codes starting at a character
// address and streams them out through a small FIFO with valid/ready handshaking.
module dma_vram_rd_char #(
   parameter int VRAM_DEPTH = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [10:0] i_start_adr,
   input  logic [11:0] i_len,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [10:0] o_vram_adr,
   output logic        o_vram_re,
   input  logic [7:0]  i_vram_data,
   output logic [7:0]  o_data,
   output logic        o_valid,
   input  logic        i_ready
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [10:0]   LAST_ADR   = 11'(VRAM_DEPTH - 1);
   localparam logic [AW+1:0] FIFO_LIMIT = (AW + 2)'(FIFO_DEPTH);

   logic [1:0]    state_q, state_d;
   logic [10:0]   cur_q, cur_d;
   logic [11:0]   remaining_q, remaining_d;
   logic          inflight_q, inflight_d;
   logic          err_q, err_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    fifo_q [FIFO_DEPTH];

   logic          active;
   logic          abort;
   logic          push;
   logic          pop;
   logic          issue;
   logic [AW+1:0] occupancy;

   assign active = (state_q == RUN) || (state_q == DRAIN);
   assign abort  = i_abort && active;

   // Abort wins over both the returning read and a consumer pop in the same cycle.
   assign pop  = o_valid && i_ready && !abort;
   assign push = inflight_q && !abort;

   // Reserve a FIFO slot for the read still in flight so the FIFO can never overflow.
   assign occupancy = {1'b0, count_q}
                    + {{(AW + 1){1'b0}}, inflight_q}
                    - {{(AW + 1){1'b0}}, pop};
   assign issue = (state_q == RUN) && !i_abort && (occupancy < FIFO_LIMIT);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      cur_d       = cur_q;
      remaining_d = remaining_q;
      err_d       = err_q;
      inflight_d  = issue;

      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end

      case (state_q)
         IDLE: begin
            if (i_start) begin
               if ((i_len == 12'd0) || (i_start_adr > LAST_ADR)) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d       = 1'b0;
                  cur_d       = i_start_adr;
                  remaining_d = i_len;
                  state_d     = RUN;
               end
            end
         end
         RUN: begin
            if (abort) begin
               state_d = DONE;
            end else if (issue) begin
               cur_d       = (cur_q == LAST_ADR) ? 11'd0 : cur_q + 11'd1;
               remaining_d = remaining_q - 12'd1;
               if (remaining_q == 12'd1) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Look at the post-pop count so o_done follows the last pop by one cycle.
            if (abort) begin
               state_d = DONE;
            end else if (!inflight_q && (count_d == '0)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         remaining_q <= '0;
         inflight_q  <= 1'b0;
         err_q       <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         err_q       <= err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         if (push) begin
            fifo_q[wr_ptr_q] <= i_vram_data;
         end
      end
   end

   assign o_busy     = (state_q != IDLE);
   assign o_done     = (state_q == DONE);
   assign o_err      = (state_q == DONE) && err_q;
   assign o_vram_re  = issue;
   assign o_vram_adr = cur_q;
   assign o_valid    = (count_q != '0);
   assign o_data     = fifo_q[rd_ptr_q];

endmodule

// File: tb/tb_dma_vram_rd_char.sv
// Randomized bench for dma_vram_rd_char: a VRAM model answers reads one cycle
// later and every transfer is scored against the memory contents and latency rules.
module tb_dma_vram_rd_char;

   localparam int VDEPTH = 2000;
   localparam int FDEPTH = 4;

   logic        clk;
   logic        rstN;
   logic        iStart;
   logic [10:0] iStartAdr;
   logic [11:0] iLen;
   logic        iAbort;
   logic        oBusy;
   logic        oDone;
   logic        oErr;
   logic [10:0] oVramAdr;
   logic        oVramRe;
   logic [7:0]  iVramData;
   logic [7:0]  oData;
   logic        oValid;
   logic        iReady;

   dma_vram_rd_char #(.VRAM_DEPTH(VDEPTH), .FIFO_DEPTH(FDEPTH)) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_start     (iStart),
      .i_start_adr (iStartAdr),
      .i_len       (iLen),
      .i_abort     (iAbort),
      .o_busy      (oBusy),
      .o_done      (oDone),
      .o_err       (oErr),
      .o_vram_adr  (oVramAdr),
      .o_vram_re   (oVramRe),
      .i_vram_data (iVramData),
      .o_data      (oData),
      .o_valid     (oValid),
      .i_ready     (iReady)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // VRAM model: a read strobed in one cycle returns its byte in the next.
   logic [7:0] vmem [VDEPTH];
   always @(posedge clk) begin
      if (oVramRe) begin
         iVramData <= vmem[oVramAdr];
      end
   end

   int testCount = 0;
   int failCount = 0;

   // Monitor state, refreshed once per cycle at the falling edge.
   int          cyc = 0;
   int          startCyc;
   int          issued;
   int          popped;
   int          maxOut;
   int          firstValidCyc;
   int          lastPopCyc;
   int          doneCyc;
   int          doneCnt;
   int          errCnt;
   int          stableBad;
   logic        prevHold;
   logic [7:0]  prevData;
   logic [10:0] reAdrQ [$];
   logic [7:0]  popQ [$];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearMonitor();
      issued        = 0;
      popped        = 0;
      maxOut        = 0;
      firstValidCyc = -1;
      lastPopCyc    = -1;
      doneCyc       = -1;
      doneCnt       = 0;
      errCnt        = 0;
      stableBad     = 0;
      prevHold      = 1'b0;
      prevData      = '0;
      reAdrQ.delete();
      popQ.delete();
   endtask

   // Sample the current cycle at the falling edge, then move to just after the next rising edge.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (oVramRe) begin
         reAdrQ.push_back(oVramAdr);
         issued++;
      end
      if (oValid && iReady) begin
         popQ.push_back(oData);
         popped++;
         lastPopCyc = cyc;
      end
      if (oValid && firstValidCyc < 0) begin
         firstValidCyc = cyc;
      end
      if (issued - popped > maxOut) begin
         maxOut = issued - popped;
      end
      if (prevHold && (!oValid || oData !== prevData)) begin
         stableBad++;
      end
      prevHold = oValid && !iReady;
      prevData = oData;
      if (oDone) begin
         doneCnt++;
         doneCyc = cyc;
         if (oErr) begin
            errCnt++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // One full transfer with a random ready pattern, optional 10-cycle stall and
   // optional stray start strobe while busy; then score it against the VRAM model.
   task automatic applyStimulus(input int adr, input int len, input int readyPct,
                                input int stallAt, input bit injectStart, input string tag);
      int budget;
      int stallLeft;
      int expAdr;
      clearMonitor();
      stallLeft = 10;
      iStart    = 1'b1;
      iStartAdr = 11'(adr);
      iLen      = 12'(len);
      iReady    = ($urandom_range(99) < readyPct);
      startCyc  = cyc + 1;
      tick();
      iStart = 1'b0;
      budget = 0;
      while (doneCnt == 0 && budget < 3000) begin
         iStart = 1'b0;
         if (injectStart && budget == 5) begin
            iStart    = 1'b1;
            iStartAdr = 11'd5;
            iLen      = 12'd1;
         end
         if (stallAt >= 0 && popped >= stallAt && stallLeft > 0) begin
            iReady = 1'b0;
            stallLeft--;
         end else begin
            iReady = ($urandom_range(99) < readyPct);
         end
         tick();
         budget++;
      end
      iStart = 1'b0;
      iReady = 1'b0;
      checkOutput({tag, "_done"}, doneCnt, 1);
      checkOutput({tag, "_err"}, errCnt, 0);
      checkOutput({tag, "_busyLow"}, oBusy, 1'b0);
      checkOutput({tag, "_popCount"}, popped, len);
      checkOutput({tag, "_reCount"}, issued, len);
      checkOutput({tag, "_firstValid"}, firstValidCyc - startCyc, 3);
      checkOutput({tag, "_doneAfterPop"}, doneCyc - lastPopCyc, 1);
      checkOutput({tag, "_outstanding"}, (maxOut <= FDEPTH), 1'b1);
      checkOutput({tag, "_stable"}, stableBad, 0);
      if (readyPct == 100 && stallAt < 0) begin
         checkOutput({tag, "_throughput"}, doneCyc - startCyc, len + 3);
      end
      for (int k = 0; k < len; k++) begin
         expAdr = (adr + k) % VDEPTH;
         if (k < reAdrQ.size()) begin
            checkOutput({tag, "_reAdr"}, reAdrQ[k], expAdr);
         end
         if (k < popQ.size()) begin
            checkOutput({tag, "_byte"}, popQ[k], vmem[expAdr]);
         end
      end
      tick();
      tick();
      checkOutput({tag, "_idleAfter"}, {oBusy, oDone, oVramRe}, 0);
   endtask

   task automatic applyReject(input int adr, input int len, input string tag);
      clearMonitor();
      iStart    = 1'b1;
      iStartAdr = 11'(adr);
      iLen      = 12'(len);
      startCyc  = cyc + 1;
      tick();
      iStart = 1'b0;
      tick();
      tick();
      checkOutput({tag, "_done"}, doneCnt, 1);
      checkOutput({tag, "_err"}, errCnt, 1);
      checkOutput({tag, "_doneLat"}, doneCyc - startCyc, 1);
      checkOutput({tag, "_noRead"}, issued, 0);
      checkOutput({tag, "_busyLow"}, oBusy, 1'b0);
   endtask

   task automatic applyAbort();
      int budget;
      int abortCyc;
      int reBefore;
      clearMonitor();
      iStart    = 1'b1;
      iStartAdr = 11'd300;
      iLen      = 12'd100;
      iReady    = 1'b1;
      tick();
      iStart = 1'b0;
      budget = 0;
      while (popped < 7 && budget < 200) begin
         tick();
         budget++;
      end
      iReady = 1'b0;
      tick();
      tick();
      tick();
      iAbort   = 1'b1;
      abortCyc = cyc + 1;
      reBefore = issued;
      tick();
      iAbort = 1'b0;
      checkOutput("abort_validLow", oValid, 1'b0);
      checkOutput("abort_doneHigh", oDone, 1'b1);
      tick();
      tick();
      tick();
      checkOutput("abort_doneLat", doneCyc - abortCyc, 1);
      checkOutput("abort_doneCnt", doneCnt, 1);
      checkOutput("abort_noRead", issued, reBefore);
      checkOutput("abort_popped", popped, 7);
      checkOutput("abort_busyLow", oBusy, 1'b0);
      for (int k = 0; k < 7 && k < popQ.size(); k++) begin
         checkOutput("abort_byte", popQ[k], vmem[300 + k]);
      end
   endtask

   task automatic applyResetMidRun();
      clearMonitor();
      iStart    = 1'b1;
      iStartAdr = 11'd100;
      iLen      = 12'd50;
      iReady    = 1'b1;
      tick();
      iStart = 1'b0;
      repeat (6) tick();
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("rstMid_outputs", {oBusy, oValid, oVramRe, oDone, oErr, oVramAdr, oData}, 0);
      tick();
      tick();
      rstN = 1'b1;
      repeat (4) tick();
      checkOutput("rstMid_noDone", doneCnt, 0);
      checkOutput("rstMid_idle", oBusy, 1'b0);
   endtask

   initial begin
      rstN      = 1'b0;
      iStart    = 1'b0;
      iStartAdr = '0;
      iLen      = '0;
      iAbort    = 1'b0;
      iReady    = 1'b0;
      iVramData = '0;
      for (int a = 0; a < VDEPTH; a++) begin
         vmem[a] = 8'(a);
      end
      #2;
      checkOutput("reset_outputs", {oBusy, oDone, oErr, oVramRe, oValid, oVramAdr, oData}, 0);
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      tick();

      applyStimulus(16, 5, 100, -1, 1'b0, "basic");
      applyStimulus(1998, 4, 100, -1, 1'b0, "wrap");

      for (int a = 0; a < VDEPTH; a++) begin
         vmem[a] = 8'($urandom);
      end

      applyStimulus(1998, 4, 100, -1, 1'b0, "wrapRand");
      applyStimulus(500, 16, 50, 3, 1'b0, "backpressure");
      applyReject(10, 0, "rejLen0");
      applyReject(2000, 5, "rejAdr");
      applyStimulus(700, 12, 70, -1, 1'b1, "startBusy");
      applyAbort();
      applyStimulus(0, 2, 100, -1, 1'b0, "postAbort");
      applyResetMidRun();
      applyStimulus(42, 9, 100, -1, 1'b0, "postReset");

      for (int t = 0; t < 5; t++) begin
         applyStimulus($urandom_range(VDEPTH - 1), $urandom_range(40, 1),
                       $urandom_range(100, 30), -1, 1'b0, "random");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/dma_vram_rd_char.md
# dma_vram_rd_char

Read-side DMA for the text-mode video RAM: on request it reads a run of character codes from VRAM, starting at a given character address, and streams them out as bytes over a valid/ready interface. It is the counterpart of the cursor/character write DMA and uses the same 11-bit VRAM character addressing. It shares the VRAM port through a read-enable strobe; an external arbiter keeps writes off that port while `o_busy` is high. Typical consumers are the UART read-back path and screen dump/scroll logic.

## Interface
- `VRAM_DEPTH`, default 2000: number of character cells (80x25); addresses wrap at `VRAM_DEPTH-1` -> 0.
- `FIFO_DEPTH`, default 4: output FIFO entries, power of two, minimum 2.

- `i_clk`  in  1  sole clock, all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle request strobe, sampled only in IDLE.
- `i_start_adr`  in  11  first character address.
- `i_len`  in  12  number of bytes to read, 0..4095.
- `i_abort`  in  1  terminate the current transfer.
- `o_busy`  out  1  high from accepted start until the cycle after `o_done`.
- `o_done`  out  1  one-cycle pulse at the end of the transfer (normal, aborted or rejected).
- `o_err`  out  1  one-cycle pulse, coincident with `o_done`, when a request is rejected.
- `o_vram_adr`  out  11  VRAM read address.
- `o_vram_re`  out  1  VRAM read enable; data is returned on `i_vram_data` exactly 1 cycle later.
- `i_vram_data`  in  8  VRAM read data.
- `o_data`  out  8  stream byte (FIFO head).
- `o_valid`  out  1  `o_data` is valid.
- `i_ready`  in  1  consumer accepts; a transfer occurs when `o_valid && i_ready`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE:** on `i_start`:
  - if `i_len == 0` or `i_start_adr >= VRAM_DEPTH`, go to DONE with `o_err` set;
  - otherwise latch the address, set `remaining = i_len`, and go to RUN.
- **RUN:** issue a read (`o_vram_re = 1`, `o_vram_adr = cur`) when `fifo_count + inflight - pop < FIFO_DEPTH`.
  - `inflight` is 1 if a read was issued the previous cycle.
  - `pop` is `o_valid && i_ready` this cycle.
  - Each issued read increments `cur` (wrapping `VRAM_DEPTH-1` -> 0) and decrements `remaining`.
  - When the final read is issued (`remaining` goes 1 -> 0), go to DRAIN.
- **Returned data:** `i_vram_data` is pushed into the FIFO in the cycle after each issued read.
- **DRAIN:** no reads are issued. When `inflight == 0` and the FIFO is empty, go to DONE.
- **DONE:** `o_done = 1` for one cycle, then IDLE. `o_busy` drops on entry to IDLE.
- **Abort:** `i_abort` in RUN or DRAIN:
  - no further reads are issued;
  - the FIFO is flushed the same cycle, so `o_valid = 0` from the next cycle;
  - the in-flight return is discarded;
  - next state is DONE.
  - `i_abort` in IDLE or DONE is ignored.
- **Priority:** abort beats a FIFO push and a pop in the same cycle.
- **Start while busy:** `i_start` in any state other than IDLE is ignored. A strobe coincident with `o_done` is also ignored.
- **FIFO simultaneity:** push and pop in the same cycle leave the count unchanged. The FIFO never overflows, because reads are gated by the occupancy rule above.
- **Outputs when not streaming:** `o_data` holds the FIFO head and is don't-care while `o_valid` is 0.

## Timing
- **Reset values:** all outputs 0, state IDLE, FIFO empty. `o_vram_adr` is 0.
- **Reset mid-transfer:** returns to IDLE immediately (asynchronous); the pending data is lost and no `o_done` is generated.
- **Start latency**, with `i_start` accepted in cycle N:
  - `o_busy` high from N+1;
  - first `o_vram_re` in N+1;
  - data captured at the end of N+2;
  - first `o_valid` in N+3.
- **Throughput:** 1 byte/cycle sustained while `i_ready` is held high.
- **End of transfer:** with the last pop in cycle M, `o_done` is high in M+1 and `o_busy` is low from M+2.
- **Backpressure:** `o_data` and `o_valid` are stable while `o_valid && !i_ready`.
- **Abort latency:** with abort in cycle A, `o_done` is high in A+1.
- **Rejected request:** with the request in cycle N, `o_done` and `o_err` are high in N+1 and no `o_vram_re` is issued.

## Test plan
- **Basic read:** VRAM model preloaded with `mem[a] = a[7:0]`; start adr=0x010, len=5, `i_ready` held 1.
  - Stream is 0x10..0x14.
  - `o_vram_re` addresses are 0x010..0x014.
  - First `o_valid` 3 cycles after start; `o_done` the cycle after the last byte.
- **Wrap-around:** start adr=1998, len=4.
  - Read addresses are 1998, 1999, 0, 1; the stream matches the memory contents.
- **Backpressure:** len=16, `i_ready` toggling in a random pattern plus a 10-cycle stall.
  - No byte is lost or duplicated.
  - At most `FIFO_DEPTH` entries are outstanding at any time.
  - `o_data` is held stable throughout the stall.
- **Rejects:**
  - len=0 -> `o_done` and `o_err` high 1 cycle after start, with zero `o_vram_re`;
  - adr=2000 -> same response;
  - `i_start` while busy -> ignored, and the current stream continues unchanged.
- **Abort:** len=100, abort after 7 bytes popped, with `i_ready` low.
  - `o_valid` is 0 from the cycle after abort.
  - `o_done` is high 1 cycle after abort, with no further `o_vram_re`.
  - A following start adr=0 len=2 streams correctly.
- **Async reset:** `i_rst_n` low mid-RUN between clock edges.
  - All outputs go to 0 immediately; no `o_done` is generated.
  - After release, a new transfer completes correctly.
